// File: rtl/multi_bit_puf_ctrl.sv
// Multi-bit PUF controller: repeated arm/settle/sample evaluations per challenge,
// per-bit majority vote with instability flags, valid/ready result handoff.

module multi_bit_puf_lane #(
  parameter int NEVAL       = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic clr,
  input  logic acc,
  input  logic vote,
  output logic resp,
  output logic unstable
);
  localparam logic [3:0] HALF = 4'(NEVAL / 2);
  localparam logic [3:0] FULL = 4'(NEVAL);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [3:0]             ones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      ones     <= '0;
      resp     <= 1'b0;
      unstable <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      if (clr)      ones <= '0;
      else if (acc) ones <= ones + {3'b000, sync_q[SYNC_STAGES-1]};
      if (vote) begin
        resp     <= (ones > HALF);
        unstable <= (ones != 4'd0) && (ones != FULL);
      end
    end
  end
endmodule

module multi_bit_puf_ctrl #(
  parameter int NBITS       = 8,
  parameter int NEVAL       = 7,
  parameter int SETTLE      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NBITS-1:0] challenge,
  output logic [NBITS-1:0] puf_challenge,
  output logic             puf_en,
  input  logic [NBITS-1:0] puf_raw,
  output logic [NBITS-1:0] resp,
  output logic [NBITS-1:0] unstable,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             busy
);
  localparam int SETTLE_TOT = SETTLE + SYNC_STAGES;
  localparam int SCW        = $clog2(SETTLE_TOT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_RELAX  = 3'd4;
  localparam logic [2:0] S_VOTE   = 3'd5;
  localparam logic [2:0] S_HOLD   = 3'd6;

  logic [2:0]     state;
  logic [3:0]     eval_cnt;
  logic [SCW-1:0] settle_cnt;
  logic           clr, acc, vote;

  // Outputs decode straight from state so reset drops them asynchronously.
  assign puf_en     = (state == S_ARM) || (state == S_SETTLE) || (state == S_SAMPLE);
  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_HOLD);
  assign clr        = (state == S_IDLE) && start;
  assign acc        = (state == S_SAMPLE);
  assign vote       = (state == S_VOTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      puf_challenge <= '0;
      eval_cnt      <= '0;
      settle_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          puf_challenge <= challenge;
          eval_cnt      <= '0;
          state         <= S_ARM;
        end
        S_ARM: begin
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == SCW'(SETTLE_TOT - 1)) state <= S_SAMPLE;
          else settle_cnt <= settle_cnt + 1'b1;
        end
        S_SAMPLE: begin
          eval_cnt <= eval_cnt + 4'd1;
          state    <= (eval_cnt == 4'(NEVAL - 1)) ? S_VOTE : S_RELAX;
        end
        S_RELAX: state <= S_ARM;
        S_VOTE:  state <= S_HOLD;
        S_HOLD:  if (resp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NBITS; i++) begin : g_lane
    multi_bit_puf_lane #(.NEVAL(NEVAL), .SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (puf_raw[i]),
      .clr      (clr),
      .acc      (acc),
      .vote     (vote),
      .resp     (resp[i]),
      .unstable (unstable[i])
    );
  end
endmodule

// File: tb/tb_multi_bit_puf_ctrl.sv
// Scoreboard bench for multi_bit_puf_ctrl with default parameters.

module tb_multi_bit_puf_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] challenge = '0;
  logic [7:0] puf_challenge;
  logic       puf_en;
  logic [7:0] puf_raw = '0;
  logic [7:0] resp, unstable;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic       busy;

  typedef struct packed { logic [7:0] resp; logic [7:0] unst; } exp_t;
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  multi_bit_puf_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
    .puf_challenge(puf_challenge), .puf_en(puf_en), .puf_raw(puf_raw),
    .resp(resp), .unstable(unstable), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive start for one cycle from a negedge; returns at the negedge of cycle 1.
  task automatic accept(input logic [7:0] ch, input bit push, input exp_t e);
    start = 1'b1; challenge = ch;
    if (push) sb.push_back(e);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    while (cyc < limit) begin
      if (resp_valid) begin ok = 1'b1; break; end
      tick(); cyc++;
    end
  endtask

  task automatic wait_en(input logic val, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (puf_en === val) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; puf_raw = '0; start = 1'b0; resp_ready = 1'b0;
    tick(); tick();
    n_chk++; if (puf_en !== 1'b0) begin n_fail++; $display("FAIL reset_puf_en got %b exp 0", puf_en); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_chk++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", resp_valid); end
    n_chk++; if (puf_challenge !== 8'h00) begin n_fail++; $display("FAIL reset_chal got %h exp 00", puf_challenge); end
    n_chk++; if ({resp, unstable} !== 16'h0000) begin n_fail++; $display("FAIL reset_resp got %h/%h exp 00/00", resp, unstable); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    exp_t e;
    int cyc;
    puf_raw = 8'hFF; resp_ready = 1'b1;
    accept(8'hA5, 1'b1, '{resp: 8'hFF, unst: 8'h00});
    cyc = 1;
    n_chk++; if (puf_challenge !== 8'hA5) begin n_fail++; $display("FAIL basic_chal got %h exp a5", puf_challenge); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b exp 1", busy); end
    challenge = 8'h00;
    while (cyc < 63) begin tick(); cyc++; end
    n_chk++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid cycle 63 got %b exp 0", resp_valid); end
    tick(); cyc++;
    n_chk++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid cycle 64 got %b exp 1", resp_valid); end
    n_chk++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL basic_sb empty scoreboard"); end
    else begin
      e = sb.pop_front();
      if ({resp, unstable} !== {e.resp, e.unst}) begin
        n_fail++; $display("FAIL basic_result got %h/%h exp %h/%h", resp, unstable, e.resp, e.unst);
      end
    end
    n_chk++; if (puf_challenge !== 8'hA5) begin n_fail++; $display("FAIL basic_chal_hold got %h exp a5", puf_challenge); end
    tick();
    n_chk++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle cycle 65 busy %b valid %b exp 0 0", busy, resp_valid); end
  endtask

  task automatic run_vote(input string name, input logic [7:0] pat [7], input exp_t e_in);
    exp_t e;
    bit ok;
    int cyc;
    resp_ready = 1'b1;
    accept(8'h3C, 1'b1, e_in);
    for (int k = 0; k < 7; k++) begin
      wait_en(1'b1, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL %s_arm eval %0d puf_en never rose", name, k); end
      puf_raw = pat[k];
      wait_en(1'b0, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL %s_relax eval %0d puf_en never fell", name, k); end
    end
    wait_valid(50, cyc, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL %s_timeout resp_valid never rose", name); end
    else if (sb.size() == 0) begin n_fail++; $display("FAIL %s_sb empty scoreboard", name); end
    else begin
      e = sb.pop_front();
      if ({resp, unstable} !== {e.resp, e.unst}) begin
        n_fail++; $display("FAIL %s_result got %h/%h exp %h/%h", name, resp, unstable, e.resp, e.unst);
      end
    end
    tick();
  endtask

  task automatic test_vote();
    logic [7:0] pa [7];
    logic [7:0] pb [7];
    for (int k = 0; k < 7; k++) begin
      pa[k] = {6'b0, (k == 0), (k < 4)};
      pb[k] = {(k < 6), 3'b000, (k == 2 || k == 4 || k == 6), 1'b1, 2'b00};
    end
    run_vote("vote_a", pa, '{resp: 8'h01, unst: 8'h03});
    run_vote("vote_b", pb, '{resp: 8'h84, unst: 8'h88});
  endtask

  task automatic test_puf_en();
    exp_t e;
    int bad, pulses;
    logic prev, exp_en;
    puf_raw = 8'h5A; resp_ready = 1'b1;
    accept(8'h77, 1'b1, '{resp: 8'h5A, unst: 8'h00});
    bad = 0; pulses = 0; prev = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      exp_en = (c <= 62) && (((c - 1) % 9) != 8);
      if (puf_en !== exp_en) bad++;
      if (puf_en && !prev) pulses++;
      prev = puf_en;
      if (c < 64) tick();
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL puf_en_wave got %0d bad cycles exp 0", bad); end
    n_chk++; if (pulses != 7) begin n_fail++; $display("FAIL puf_en_pulses got %0d exp 7", pulses); end
    n_chk++;
    if (resp_valid !== 1'b1 || sb.size() == 0) begin n_fail++; $display("FAIL puf_en_valid got %b exp 1", resp_valid); end
    else begin
      e = sb.pop_front();
      if ({resp, unstable} !== {e.resp, e.unst}) begin
        n_fail++; $display("FAIL puf_en_result got %h/%h exp %h/%h", resp, unstable, e.resp, e.unst);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit ok;
    int cyc, bad;
    puf_raw = 8'h0F; resp_ready = 1'b0;
    accept(8'hC3, 1'b1, '{resp: 8'h0F, unst: 8'h00});
    wait_valid(100, cyc, ok);
    n_chk++;
    if (!ok || sb.size() == 0) begin n_fail++; $display("FAIL bp_timeout resp_valid never rose"); end
    else begin
      e = sb.pop_front();
      if ({resp, unstable} !== {e.resp, e.unst}) begin
        n_fail++; $display("FAIL bp_result got %h/%h exp %h/%h", resp, unstable, e.resp, e.unst);
      end
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      start = ~start; challenge = 8'($urandom); puf_raw = 8'($urandom);
      tick();
      if (resp !== 8'h0F || unstable !== 8'h00 || puf_challenge !== 8'hC3 || resp_valid !== 1'b1) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
    start = 1'b0; resp_ready = 1'b1;
    tick();
    n_chk++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release valid %b busy %b exp 0 0", resp_valid, busy); end
    n_chk++; if (puf_challenge !== 8'hC3) begin n_fail++; $display("FAIL bp_chal_idle got %h exp c3", puf_challenge); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit ok;
    int cyc;
    puf_raw = 8'h00; resp_ready = 1'b1;
    accept(8'h11, 1'b0, '0);
    repeat (19) tick();
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (puf_en !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_async en %b busy %b valid %b exp 0 0 0", puf_en, busy, resp_valid);
    end
    n_chk++; if (puf_challenge !== 8'h00 || resp !== 8'h00) begin
      n_fail++; $display("FAIL rst_clear chal %h resp %h exp 00 00", puf_challenge, resp);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    puf_raw = 8'hF0;
    accept(8'h5A, 1'b1, '{resp: 8'hF0, unst: 8'h00});
    wait_valid(100, cyc, ok);
    n_chk++; if (!ok || cyc + 1 != 64) begin n_fail++; $display("FAIL rst_latency got cycle %0d exp 64", cyc + 1); end
    n_chk++;
    if (!ok || sb.size() == 0) begin n_fail++; $display("FAIL rst_result missing"); end
    else begin
      e = sb.pop_front();
      if ({resp, unstable} !== {e.resp, e.unst}) begin
        n_fail++; $display("FAIL rst_result got %h/%h exp %h/%h", resp, unstable, e.resp, e.unst);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit ok;
    int c1, c2, gap;
    puf_raw = 8'h81; resp_ready = 1'b1;
    sb.push_back('{resp: 8'h81, unst: 8'h00});
    sb.push_back('{resp: 8'h81, unst: 8'h00});
    start = 1'b1; challenge = 8'h99;
    tick();
    wait_valid(100, c1, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL b2b_first resp_valid never rose"); end
    else begin
      e = sb.pop_front();
      if ({resp, unstable} !== {e.resp, e.unst}) begin
        n_fail++; $display("FAIL b2b_first_result got %h/%h exp %h/%h", resp, unstable, e.resp, e.unst);
      end
    end
    tick();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle busy %b exp 0", busy); end
    tick();
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart busy %b exp 1", busy); end
    wait_valid(100, c2, ok);
    start = 1'b0;
    gap = c2 + 2;
    n_chk++; if (!ok || gap != 65) begin n_fail++; $display("FAIL b2b_gap got %0d exp 65", gap); end
    n_chk++;
    if (!ok || sb.size() == 0) begin n_fail++; $display("FAIL b2b_second missing"); end
    else begin
      e = sb.pop_front();
      if ({resp, unstable} !== {e.resp, e.unst}) begin
        n_fail++; $display("FAIL b2b_second_result got %h/%h exp %h/%h", resp, unstable, e.resp, e.unst);
      end
    end
    tick(); tick();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end busy %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vote();
    test_puf_en();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain %0d entries left exp 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
